vproc_result_pack: RTL

VPROC_RESULT_PACK -- requirements
Module: vproc_result_pack

---
 rtl/vproc_result_pack.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vproc_result_pack.sv
// Packs OP_W (or OP_W/2 narrow) result beats into one VREG_W-wide vector register write.
// Optional macro VPROC_PACK_OUT_BUF_EN adds an output register so assembly continues while a write waits.
module vproc_result_pack #(
    parameter int VREG_W = 128,
    parameter int OP_W   = 32
) (
    input  logic                  clk_i,
    input  logic                  sync_rst_i,
    input  logic                  pipe_in_valid_i,
    output logic                  pipe_in_ready_o,
    input  logic [OP_W-1:0]       pipe_in_res_i,
    input  logic [OP_W/8-1:0]     pipe_in_mask_i,
    input  logic                  pipe_in_narrow_i,
    input  logic                  pipe_in_last_i,
    input  logic [4:0]            pipe_in_vaddr_i,
    output logic                  vreg_wr_valid_o,
    input  logic                  vreg_wr_ready_i,
    output logic [4:0]            vreg_wr_addr_o,
    output logic [VREG_W/8-1:0]   vreg_wr_be_o,
    output logic [VREG_W-1:0]     vreg_wr_o
);
    localparam int NUM_HALF = 2 * VREG_W / OP_W;
    localparam int HALF_W   = OP_W / 2;
    localparam int HALF_B   = OP_W / 16;
    localparam int OP_B     = OP_W / 8;
    localparam int BE_W     = VREG_W / 8;
    localparam int CNT_W    = $clog2(NUM_HALF + 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              narrow_q;
    logic [4:0]        vaddr_q;
    logic [VREG_W-1:0] asm_data;
    logic [BE_W-1:0]   asm_be;

    logic              first;
    logic              narrow_eff;
    logic [4:0]        vaddr_eff;
    logic              accept;
    logic              done;
    logic [CNT_W-1:0]  cnt_next;
    logic [OP_W-1:0]   beat_res;
    logic [OP_B-1:0]   beat_mask;
    logic [VREG_W-1:0] new_data;
    logic [BE_W-1:0]   new_be;

    // Width and address are captured on the first beat; later beats reuse the held values.
    always_comb begin
        first      = (cnt == '0);
        narrow_eff = first ? pipe_in_narrow_i : narrow_q;
        vaddr_eff  = first ? pipe_in_vaddr_i : vaddr_q;
        beat_res   = pipe_in_res_i;
        beat_mask  = pipe_in_mask_i;
        if (narrow_eff) begin
            beat_res  = {{HALF_W{1'b0}}, pipe_in_res_i[HALF_W-1:0]};
            beat_mask = {{(OP_B-HALF_B){1'b0}}, pipe_in_mask_i[HALF_B-1:0]};
        end
        cnt_next = cnt + (narrow_eff ? CNT_W'(1) : CNT_W'(2));
        done     = (cnt_next == CNT_W'(NUM_HALF)) || pipe_in_last_i;
        new_data = VREG_W'(beat_res) << (cnt * HALF_W);
        new_be   = BE_W'(beat_mask) << (cnt * HALF_B);
        // A first beat starts from zero so a flushed register never carries stale bytes.
        if (!first) begin
            new_data = new_data | asm_data;
            new_be   = new_be | asm_be;
        end
        accept = pipe_in_valid_i && pipe_in_ready_o;
    end

    assign pipe_in_ready_o = !sync_rst_i && (state == FILL);

`ifdef VPROC_PACK_OUT_BUF_EN
    logic              out_valid;
    logic [4:0]        out_addr;
    logic [BE_W-1:0]   out_be;
    logic [VREG_W-1:0] out_data;
    logic              out_free;

    assign out_free = !out_valid || vreg_wr_ready_i;

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state     <= FILL;
            cnt       <= '0;
            narrow_q  <= 1'b0;
            vaddr_q   <= '0;
            asm_data  <= '0;
            asm_be    <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_be    <= '0;
            out_data  <= '0;
        end else begin
            if (out_valid && vreg_wr_ready_i) out_valid <= 1'b0;
            case (state)
                FILL: if (accept) begin
                    asm_data <= new_data;
                    asm_be   <= new_be;
                    narrow_q <= narrow_eff;
                    vaddr_q  <= vaddr_eff;
                    cnt      <= cnt_next;
                    if (done) begin
                        // Bypass straight into the output register when it is free this cycle.
                        if (out_free) begin
                            out_valid <= 1'b1;
                            out_addr  <= vaddr_eff;
                            out_be    <= new_be;
                            out_data  <= new_data;
                            cnt       <= '0;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: if (vreg_wr_ready_i) begin
                    out_valid <= 1'b1;
                    out_addr  <= vaddr_q;
                    out_be    <= asm_be;
                    out_data  <= asm_data;
                    state     <= FILL;
                    cnt       <= '0;
                end
                default: state <= FILL;
            endcase
        end
    end

    assign vreg_wr_valid_o = out_valid;
    assign vreg_wr_addr_o  = out_addr;
    assign vreg_wr_be_o    = out_be;
    assign vreg_wr_o       = out_data;
`else
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state    <= FILL;
            cnt      <= '0;
            narrow_q <= 1'b0;
            vaddr_q  <= '0;
            asm_data <= '0;
            asm_be   <= '0;
        end else begin
            case (state)
                FILL: if (accept) begin
                    asm_data <= new_data;
                    asm_be   <= new_be;
                    narrow_q <= narrow_eff;
                    vaddr_q  <= vaddr_eff;
                    cnt      <= cnt_next;
                    if (done) state <= HOLD;
                end
                HOLD: if (vreg_wr_ready_i) begin
                    state <= FILL;
                    cnt   <= '0;
                end
                default: state <= FILL;
            endcase
        end
    end

    assign vreg_wr_valid_o = (state == HOLD);
    assign vreg_wr_addr_o  = vaddr_q;
    assign vreg_wr_be_o    = asm_be;
    assign vreg_wr_o       = asm_data;
`endif

endmodule
